// File: rtl/math_mac_pkg.sv
// Shared types and helpers for the 8x8 dot-product MAC and its Wallace-tree multiplier.
package math_mac_pkg;

    localparam int MAC_OP_W   = 8;
    localparam int MAC_PROD_W = 16;

    typedef struct packed {
        logic [MAC_OP_W-1:0] a;
        logic [MAC_OP_W-1:0] b;
        logic                last;
    } mac_s1_t;

    // Carry word of a 3:2 compressor, already shifted into the next column.
    function automatic logic [MAC_PROD_W-1:0] csa_carry(
        input logic [MAC_PROD_W-1:0] x,
        input logic [MAC_PROD_W-1:0] y,
        input logic [MAC_PROD_W-1:0] z
    );
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

endpackage

// File: rtl/math_dot_product_mac_8_if.sv
// Operand/result handshake bundle of the dot-product MAC; the DUT side uses the slave modport.
interface math_dot_product_mac_8_if #(
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 9
);
    logic                 i_flush;
    logic                 i_valid;
    logic                 o_ready;
    logic [7:0]           i_multiplier;
    logic [7:0]           i_multiplicand;
    logic                 i_last;
    logic                 o_valid;
    logic                 i_ready;
    logic [ACC_WIDTH-1:0] o_result;
    logic [CNT_WIDTH-1:0] o_count;
    logic                 o_overflow;

    modport master (
        output i_flush, i_valid, i_multiplier, i_multiplicand, i_last, i_ready,
        input  o_ready, o_valid, o_result, o_count, o_overflow
    );

    modport slave (
        input  i_flush, i_valid, i_multiplier, i_multiplicand, i_last, i_ready,
        output o_ready, o_valid, o_result, o_count, o_overflow
    );
endinterface

// File: rtl/math_multiplier_wallace_tree_8.sv
// Combinational 8x8 unsigned multiplier: partial products reduced 8->6->4->3->2 with 3:2 compressors.
module math_multiplier_wallace_tree_8
    import math_mac_pkg::*;
(
    input  logic [MAC_OP_W-1:0]   i_multiplier,
    input  logic [MAC_OP_W-1:0]   i_multiplicand,
    output logic [MAC_PROD_W-1:0] ow_product
);
    logic [MAC_OP_W-1:0][MAC_PROD_W-1:0] pp;

    for (genvar i = 0; i < MAC_OP_W; i++) begin : g_pp
        assign pp[i] = {{(MAC_PROD_W-MAC_OP_W){1'b0}}, i_multiplier & {MAC_OP_W{i_multiplicand[i]}}} << i;
    end

    logic [MAC_PROD_W-1:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

    assign s0 = pp[0] ^ pp[1] ^ pp[2];
    assign c0 = csa_carry(pp[0], pp[1], pp[2]);
    assign s1 = pp[3] ^ pp[4] ^ pp[5];
    assign c1 = csa_carry(pp[3], pp[4], pp[5]);

    assign s2 = s0 ^ c0 ^ s1;
    assign c2 = csa_carry(s0, c0, s1);
    assign s3 = c1 ^ pp[6] ^ pp[7];
    assign c3 = csa_carry(c1, pp[6], pp[7]);

    assign s4 = s2 ^ c2 ^ s3;
    assign c4 = csa_carry(s2, c2, s3);

    assign s5 = s4 ^ c4 ^ c3;
    assign c5 = csa_carry(s4, c4, c3);

    // The product fits in 16 bits, so dropping carries past bit 15 is exact.
    assign ow_product = s5 + c5;
endmodule

// File: rtl/math_dot_product_mac_8.sv
// Streaming 8x8 unsigned dot-product engine: S1 operand register, multiply, S2 accumulate,
// result register held under valid/ready.
module math_dot_product_mac_8
    import math_mac_pkg::*;
#(
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 9
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    math_dot_product_mac_8_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic                  rst_done;
    logic                  advance, accept, complete;
    logic                  s1_v;
    mac_s1_t               s1;
    logic [MAC_PROD_W-1:0] prod;
    logic [ACC_WIDTH-1:0]  acc;
    logic [CNT_WIDTH-1:0]  cnt, cnt_n;
    logic                  ovf, ovf_n, cnt_max;
    logic [ACC_WIDTH:0]    sum_n;

    // o_ready stays low until the first edge after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) rst_done <= 1'b0;
        else          rst_done <= 1'b1;

    assign advance     = !bus.o_valid || bus.i_ready;
    assign bus.o_ready = rst_done && advance && !bus.i_flush;
    assign accept      = bus.i_valid && bus.o_ready;

    math_multiplier_wallace_tree_8 u_mul (
        .i_multiplier   (s1.a),
        .i_multiplicand (s1.b),
        .ow_product     (prod)
    );

    assign sum_n    = {1'b0, acc} + {{(ACC_WIDTH+1-MAC_PROD_W){1'b0}}, prod};
    assign cnt_max  = &cnt;
    assign cnt_n    = cnt_max ? cnt : cnt + CNT_ONE;
    assign ovf_n    = ovf || sum_n[ACC_WIDTH] || cnt_max;
    assign complete = !bus.i_flush && advance && s1_v && s1.last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_v <= 1'b0;
            s1   <= '0;
            acc  <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else if (bus.i_flush) begin
            s1_v <= 1'b0;
            acc  <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else if (advance) begin
            s1_v <= accept;
            if (accept) begin
                s1.a    <= bus.i_multiplier;
                s1.b    <= bus.i_multiplicand;
                s1.last <= bus.i_last;
            end
            if (s1_v) begin
                if (s1.last) begin
                    acc <= '0;
                    cnt <= '0;
                    ovf <= 1'b0;
                end else begin
                    acc <= sum_n[ACC_WIDTH-1:0];
                    cnt <= cnt_n;
                    ovf <= ovf_n;
                end
            end
        end
    end

    // A completing vector on the same edge as a downstream accept keeps o_valid high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_valid    <= 1'b0;
            bus.o_result   <= '0;
            bus.o_count    <= '0;
            bus.o_overflow <= 1'b0;
        end else if (complete) begin
            bus.o_valid    <= 1'b1;
            bus.o_result   <= sum_n[ACC_WIDTH-1:0];
            bus.o_count    <= cnt_n;
            bus.o_overflow <= ovf_n;
        end else if (bus.i_ready) begin
            bus.o_valid    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_math_dot_product_mac_8.sv
// Directed and randomized checks of math_dot_product_mac_8 against a whole-vector reference model.
module tb_math_dot_product_mac_8;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 i_clk = ~i_clk;

    math_dot_product_mac_8_if #(.ACC_WIDTH(24), .CNT_WIDTH(9)) bus ();
    math_dot_product_mac_8_if #(.ACC_WIDTH(16), .CNT_WIDTH(9)) bus16 ();

    math_dot_product_mac_8 #(.ACC_WIDTH(24), .CNT_WIDTH(9)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus)
    );
    math_dot_product_mac_8 #(.ACC_WIDTH(16), .CNT_WIDTH(9)) dut16 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus16)
    );

    typedef struct {
        longint unsigned r;
        int              c;
        bit              o;
    } exp_t;

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        bus.i_valid = 0;   bus.i_flush = 0;   bus.i_last = 0;
        bus.i_multiplier = 0;   bus.i_multiplicand = 0;   bus.i_ready = 1;
        bus16.i_valid = 0; bus16.i_flush = 0; bus16.i_last = 0;
        bus16.i_multiplier = 0; bus16.i_multiplicand = 0; bus16.i_ready = 1;
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] b, input logic l);
        bus.i_valid = 1; bus.i_multiplier = a; bus.i_multiplicand = b; bus.i_last = l;
    endtask

    task automatic test_reset();
        idle();
        i_rst_n = 0;
        cyc(); cyc();
        checks++;
        if ({bus.o_valid, bus.o_ready, bus.o_result, bus.o_count, bus.o_overflow, bus16.o_ready} !== '0)
            $display("FAIL reset_outputs: got v=%0b rdy=%0b r=%h c=%0d o=%0b rdy16=%0b, want all 0",
                     bus.o_valid, bus.o_ready, bus.o_result, bus.o_count, bus.o_overflow, bus16.o_ready);
        if ({bus.o_valid, bus.o_ready, bus.o_result, bus.o_count, bus.o_overflow, bus16.o_ready} !== '0)
            errors++;
        i_rst_n = 1;
        #1;
        checks++;
        if (bus.o_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_early: got %0b want 0", bus.o_ready);
        end
        cyc();
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after: got %0b want 1", bus.o_ready);
        end
    endtask

    task automatic test_vector();
        put(8'd2, 8'd3, 1'b0);     cyc();
        put(8'd4, 8'd5, 1'b0);     cyc();
        put(8'd255, 8'd255, 1'b1); cyc();
        bus.i_valid = 0;
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++; $display("FAIL vec_latency: o_valid got %0b one clk after last, want 0", bus.o_valid);
        end
        cyc();
        checks++;
        if ({bus.o_valid, bus.o_result, bus.o_count, bus.o_overflow} !== {1'b1, 24'h00FE1B, 9'd3, 1'b0}) begin
            errors++;
            $display("FAIL vec_result: got v=%0b r=%h c=%0d o=%0b want v=1 r=00fe1b c=3 o=0",
                     bus.o_valid, bus.o_result, bus.o_count, bus.o_overflow);
        end
        cyc();
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++; $display("FAIL vec_drop: o_valid got %0b want 0", bus.o_valid);
        end
    endtask

    task automatic test_back_to_back();
        put(8'hFF, 8'hFF, 1'b1); cyc();
        bus.i_valid = 0;         cyc();
        checks++;
        if ({bus.o_valid, bus.o_result, bus.o_count, bus.o_overflow} !== {1'b1, 24'h00FE01, 9'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_pair: got v=%0b r=%h c=%0d o=%0b want v=1 r=00fe01 c=1 o=0",
                     bus.o_valid, bus.o_result, bus.o_count, bus.o_overflow);
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 4) put(8'(2*i+1), 8'(2*i+2), 1'b1);
            else       bus.i_valid = 0;
            cyc();
            if (i >= 1 && i <= 4) begin
                checks++;
                if ({bus.o_valid, bus.o_result, bus.o_count} !== {1'b1, 24'((2*i-1)*(2*i)), 9'd1}) begin
                    errors++;
                    $display("FAIL b2b_%0d: got v=%0b r=%0d c=%0d want v=1 r=%0d c=1",
                             i, bus.o_valid, bus.o_result, bus.o_count, (2*i-1)*(2*i));
                end
            end else if (i == 5) begin
                checks++;
                if (bus.o_valid !== 1'b0) begin
                    errors++; $display("FAIL b2b_end: o_valid got %0b want 0", bus.o_valid);
                end
            end
        end
    endtask

    task automatic test_overflow();
        bus16.i_valid = 1; bus16.i_multiplier = 8'd255; bus16.i_multiplicand = 8'd255; bus16.i_last = 0;
        cyc();
        bus16.i_last = 1;
        cyc();
        bus16.i_valid = 0;
        cyc();
        checks++;
        if ({bus16.o_valid, bus16.o_result, bus16.o_count, bus16.o_overflow} !== {1'b1, 16'hFC02, 9'd2, 1'b1}) begin
            errors++;
            $display("FAIL ovf16_result: got v=%0b r=%h c=%0d o=%0b want v=1 r=fc02 c=2 o=1",
                     bus16.o_valid, bus16.o_result, bus16.o_count, bus16.o_overflow);
        end
        bus16.i_valid = 1; bus16.i_multiplier = 8'd1; bus16.i_multiplicand = 8'd1; bus16.i_last = 1;
        cyc();
        bus16.i_valid = 0;
        cyc();
        checks++;
        if ({bus16.o_valid, bus16.o_result, bus16.o_count, bus16.o_overflow} !== {1'b1, 16'h0001, 9'd1, 1'b0}) begin
            errors++;
            $display("FAIL ovf16_clear: got v=%0b r=%h c=%0d o=%0b want v=1 r=0001 c=1 o=0",
                     bus16.o_valid, bus16.o_result, bus16.o_count, bus16.o_overflow);
        end
        cyc();
    endtask

    task automatic test_stall();
        bus.i_ready = 0;
        put(8'd6, 8'd7, 1'b1); cyc();
        bus.i_valid = 0;       cyc();
        checks++;
        if ({bus.o_valid, bus.o_result, bus.o_count} !== {1'b1, 24'd42, 9'd1}) begin
            errors++;
            $display("FAIL stall_first: got v=%0b r=%0d c=%0d want v=1 r=42 c=1", bus.o_valid, bus.o_result, bus.o_count);
        end
        put(8'd2, 8'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({bus.o_ready, bus.o_valid, bus.o_result, bus.o_count} !== {1'b0, 1'b1, 24'd42, 9'd1}) begin
                errors++;
                $display("FAIL stall_hold_%0d: got rdy=%0b v=%0b r=%0d c=%0d want rdy=0 v=1 r=42 c=1",
                         i, bus.o_ready, bus.o_valid, bus.o_result, bus.o_count);
            end
            cyc();
        end
        bus.i_ready = 1;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release_ready: got %0b want 1", bus.o_ready);
        end
        cyc();
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release_drop: o_valid got %0b want 0", bus.o_valid);
        end
        put(8'd3, 8'd3, 1'b1); cyc();
        bus.i_valid = 0;       cyc();
        checks++;
        if ({bus.o_valid, bus.o_result, bus.o_count} !== {1'b1, 24'd13, 9'd2}) begin
            errors++;
            $display("FAIL stall_next_vec: got v=%0b r=%0d c=%0d want v=1 r=13 c=2", bus.o_valid, bus.o_result, bus.o_count);
        end
        cyc();
    endtask

    task automatic test_flush();
        put(8'd10, 8'd10, 1'b0); cyc();
        put(8'd20, 8'd20, 1'b0); cyc();
        bus.i_valid = 0; bus.i_flush = 1;
        #1;
        checks++;
        if (bus.o_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %0b want 0", bus.o_ready);
        end
        cyc();
        bus.i_flush = 0;
        put(8'd1, 8'd1, 1'b1); cyc();
        bus.i_valid = 0;       cyc();
        checks++;
        if ({bus.o_valid, bus.o_result, bus.o_count, bus.o_overflow} !== {1'b1, 24'd1, 9'd1, 1'b0}) begin
            errors++;
            $display("FAIL flush_partial: got v=%0b r=%0d c=%0d o=%0b want v=1 r=1 c=1 o=0",
                     bus.o_valid, bus.o_result, bus.o_count, bus.o_overflow);
        end
        cyc();
        put(8'd9, 8'd9, 1'b1); cyc();
        bus.i_valid = 0; bus.i_flush = 1; cyc();
        bus.i_flush = 0; cyc();
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++; $display("FAIL flush_last_s1: o_valid got %0b want 0", bus.o_valid);
        end
        bus.i_ready = 0;
        put(8'd4, 8'd4, 1'b1); cyc();
        bus.i_valid = 0;       cyc();
        bus.i_flush = 1;       cyc();
        bus.i_flush = 0;
        checks++;
        if ({bus.o_valid, bus.o_result, bus.o_count} !== {1'b1, 24'd16, 9'd1}) begin
            errors++;
            $display("FAIL flush_pending: got v=%0b r=%0d c=%0d want v=1 r=16 c=1", bus.o_valid, bus.o_result, bus.o_count);
        end
        bus.i_ready = 1; cyc();
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++; $display("FAIL flush_pending_drop: o_valid got %0b want 0", bus.o_valid);
        end
    endtask

    task automatic test_async_reset();
        bus.i_ready = 0;
        put(8'd5, 8'd5, 1'b1); cyc();
        bus.i_ready = 1;
        put(8'd5, 8'd5, 1'b0); cyc();
        put(8'd6, 8'd6, 1'b0); cyc();
        bus.i_valid = 0;
        #2;
        i_rst_n = 0;
        #1;
        checks++;
        if ({bus.o_valid, bus.o_ready, bus.o_result, bus.o_count, bus.o_overflow} !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%0b rdy=%0b r=%h c=%0d o=%0b want all 0",
                     bus.o_valid, bus.o_ready, bus.o_result, bus.o_count, bus.o_overflow);
        end
        cyc();
        i_rst_n = 1;
        cyc();
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset_ready: got %0b want 1", bus.o_ready);
        end
        put(8'd3, 8'd3, 1'b1); cyc();
        bus.i_valid = 0;       cyc();
        checks++;
        if ({bus.o_valid, bus.o_result, bus.o_count, bus.o_overflow} !== {1'b1, 24'd9, 9'd1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_after: got v=%0b r=%0d c=%0d o=%0b want v=1 r=9 c=1 o=0",
                     bus.o_valid, bus.o_result, bus.o_count, bus.o_overflow);
        end
        cyc();
    endtask

    task automatic test_random();
        int unsigned pa[$], pb[$];
        bit          pl[$];
        exp_t        exp_q[$];
        exp_t        e;
        int          idx = 0;
        int          ncyc = 0;
        for (int v = 0; v < 30; v++) begin
            longint unsigned sum = 0;
            int n = (v == 10) ? 520 : int'($urandom_range(1, 6));
            for (int k = 0; k < n; k++) begin
                int unsigned a = (v == 10) ? $urandom_range(200, 255) : $urandom_range(0, 255);
                int unsigned b = (v == 10) ? $urandom_range(200, 255) : $urandom_range(0, 255);
                pa.push_back(a); pb.push_back(b); pl.push_back(k == n - 1);
                sum += longint'(a) * longint'(b);
            end
            e.r = sum % (64'd1 << 24);
            e.c = (n > 511) ? 511 : n;
            e.o = (sum >= (64'd1 << 24)) || (n > 511);
            exp_q.push_back(e);
        end
        while ((idx < pa.size() || exp_q.size() > 0) && ncyc < 20000) begin
            bus.i_valid = (idx < pa.size()) && ($urandom_range(0, 3) != 0);
            if (idx < pa.size()) begin
                bus.i_multiplier = 8'(pa[idx]); bus.i_multiplicand = 8'(pb[idx]); bus.i_last = pl[idx];
            end
            bus.i_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.o_valid && bus.i_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra: unexpected result r=%0d c=%0d", bus.o_result, bus.o_count);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.o_result, bus.o_count, bus.o_overflow} !== {24'(e.r), 9'(e.c), e.o}) begin
                        errors++;
                        $display("FAIL rand_result: got r=%0d c=%0d o=%0b want r=%0d c=%0d o=%0b",
                                 bus.o_result, bus.o_count, bus.o_overflow, e.r, e.c, e.o);
                    end
                end
            end
            if (bus.i_valid && bus.o_ready) idx++;
            cyc();
            ncyc++;
        end
        bus.i_valid = 0; bus.i_ready = 1;
        checks++;
        if (idx < pa.size() || exp_q.size() > 0) begin
            errors++;
            $display("FAIL rand_timeout: sent %0d of %0d pairs, %0d results outstanding", idx, pa.size(), exp_q.size());
        end
        cyc(); cyc();
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++; $display("FAIL rand_tail: o_valid got %0b want 0", bus.o_valid);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vector();
        test_back_to_back();
        test_overflow();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
